// File: rtl/ipv4_pkg.sv
// Shared IPv4 header types and constants for the header extraction and checksum path.
// The header struct is laid out in network (wire) field order, MSB first.
package ipv4_pkg;

    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] length;
        logic [15:0] id;
        logic [2:0]  flags;
        logic [12:0] frag_offset;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] checksum;
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
    } ipv4_hdr_t;

    localparam int unsigned IPV4_MIN_HDR_BYTES = 20;
    localparam logic [3:0]  IPV4_VERSION       = 4'd4;

endpackage

// File: rtl/ipv4_header_extract.sv
// Assembles the first 20 bytes of each IPv4 packet into a 160-bit header word,
// drops malformed packets and counts emitted headers and drops.
module ipv4_header_extract
    import ipv4_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 sresetn,
    // Packet stream slave
    input  logic [63:0]          pkt_in_tdata_i,
    input  logic [7:0]           pkt_in_tkeep_i,
    input  logic                 pkt_in_tvalid_i,
    input  logic                 pkt_in_tlast_i,
    output logic                 pkt_in_tready_o,
    // Header word master
    output logic [159:0]         ipv4_header_tdata_o,
    output logic [19:0]          ipv4_header_tstrb_o,
    output logic [19:0]          ipv4_header_tkeep_o,
    output logic                 ipv4_header_tvalid_o,
    output logic                 ipv4_header_tlast_o,
    output logic                 ipv4_header_tid_o,
    output logic                 ipv4_header_tdest_o,
    output logic                 ipv4_header_tuser_o,
    // Status
    output logic                 err_short_o,
    output logic                 err_version_o,
    output logic                 err_length_o,
    output logic                 opt_present_o,
    output logic [CNT_WIDTH-1:0] hdr_count_o,
    output logic [CNT_WIDTH-1:0] drop_count_o
);

    typedef enum logic [1:0] {StHdr0, StHdr1, StHdr2, StPayload} state_e;

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    state_e                 state_q;
    logic [159:0]           hdr_q;
    logic [159:0]           out_tdata_q;
    logic                   out_tvalid_q;
    logic                   err_short_q;
    logic                   err_version_q;
    logic                   err_length_q;
    logic                   opt_present_q;
    logic [CNT_WIDTH-1:0]   hdr_count_q;
    logic [CNT_WIDTH-1:0]   drop_count_q;

    ipv4_hdr_t full_hdr;
    logic      bad_version;
    logic      bad_length;
    logic      has_opts;
    logic      tail_short;
    logic      unused_keep;

    // The HDR2 beat completes the header in the same cycle the decision is registered.
    always_comb begin
        full_hdr    = ipv4_hdr_t'({hdr_q[159:32], pkt_in_tdata_i[63:32]});
        bad_version = full_hdr.version != IPV4_VERSION;
        bad_length  = full_hdr.length < 16'(IPV4_MIN_HDR_BYTES);
        has_opts    = full_hdr.ihl > 4'd5;
        tail_short  = pkt_in_tlast_i && (pkt_in_tkeep_i[7:4] != 4'hF);
    end

    assign unused_keep = ^pkt_in_tkeep_i[3:0];

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q       <= StHdr0;
            hdr_q         <= '0;
            out_tdata_q   <= '0;
            out_tvalid_q  <= 1'b0;
            err_short_q   <= 1'b0;
            err_version_q <= 1'b0;
            err_length_q  <= 1'b0;
            opt_present_q <= 1'b0;
            hdr_count_q   <= '0;
            drop_count_q  <= '0;
        end else begin
            out_tvalid_q  <= 1'b0;
            err_short_q   <= 1'b0;
            err_version_q <= 1'b0;
            err_length_q  <= 1'b0;
            opt_present_q <= 1'b0;
            if (pkt_in_tvalid_i) begin
                unique case (state_q)
                    StHdr0: begin
                        hdr_q[159:96] <= pkt_in_tdata_i;
                        if (pkt_in_tlast_i) begin
                            err_short_q  <= 1'b1;
                            drop_count_q <= drop_count_q + CntOne;
                        end else begin
                            state_q <= StHdr1;
                        end
                    end
                    StHdr1: begin
                        hdr_q[95:32] <= pkt_in_tdata_i;
                        if (pkt_in_tlast_i) begin
                            err_short_q  <= 1'b1;
                            drop_count_q <= drop_count_q + CntOne;
                            state_q      <= StHdr0;
                        end else begin
                            state_q <= StHdr2;
                        end
                    end
                    StHdr2: begin
                        hdr_q[31:0] <= pkt_in_tdata_i[63:32];
                        state_q     <= pkt_in_tlast_i ? StHdr0 : StPayload;
                        if (tail_short) begin
                            err_short_q  <= 1'b1;
                            drop_count_q <= drop_count_q + CntOne;
                        end else begin
                            err_version_q <= bad_version;
                            err_length_q  <= bad_length;
                            opt_present_q <= has_opts;
                            if (bad_version || bad_length) begin
                                drop_count_q <= drop_count_q + CntOne;
                            end else begin
                                // Output word only changes on an emit, so it stays stable
                                // while the next packet's first beat is captured.
                                out_tvalid_q <= 1'b1;
                                out_tdata_q  <= full_hdr;
                                hdr_count_q  <= hdr_count_q + CntOne;
                            end
                        end
                    end
                    StPayload: begin
                        if (pkt_in_tlast_i) begin
                            state_q <= StHdr0;
                        end
                    end
                    default: state_q <= StHdr0;
                endcase
            end
        end
    end

    assign pkt_in_tready_o      = 1'b1;
    assign ipv4_header_tdata_o  = out_tdata_q;
    assign ipv4_header_tvalid_o = out_tvalid_q;
    assign ipv4_header_tlast_o  = out_tvalid_q;
    assign ipv4_header_tstrb_o  = '1;
    assign ipv4_header_tkeep_o  = '1;
    assign ipv4_header_tid_o    = 1'b0;
    assign ipv4_header_tdest_o  = 1'b0;
    assign ipv4_header_tuser_o  = 1'b0;
    assign err_short_o          = err_short_q;
    assign err_version_o        = err_version_q;
    assign err_length_o         = err_length_q;
    assign opt_present_o        = opt_present_q;
    assign hdr_count_o          = hdr_count_q;
    assign drop_count_o         = drop_count_q;

endmodule

// File: tb/tb_ipv4_header_extract.sv
// Scoreboard bench for ipv4_header_extract: a byte-level packet model predicts each
// header/drop outcome and a monitor checks every DUT output pulse against it.
module tb_ipv4_header_extract;

    localparam int unsigned CW   = 4;
    localparam int          MASK = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          sresetn = 1'b0;
    logic [63:0]   in_tdata = '0;
    logic [7:0]    in_tkeep = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tlast = 1'b0;
    logic          in_tready;
    logic [159:0]  hdr_tdata;
    logic [19:0]   hdr_tstrb;
    logic [19:0]   hdr_tkeep;
    logic          hdr_tvalid;
    logic          hdr_tlast;
    logic          hdr_tid;
    logic          hdr_tdest;
    logic          hdr_tuser;
    logic          err_short;
    logic          err_version;
    logic          err_length;
    logic          opt_present;
    logic [CW-1:0] hdr_count;
    logic [CW-1:0] drop_count;

    ipv4_header_extract #(.CNT_WIDTH(CW)) dut (
        .clk                  (clk),
        .sresetn              (sresetn),
        .pkt_in_tdata_i       (in_tdata),
        .pkt_in_tkeep_i       (in_tkeep),
        .pkt_in_tvalid_i      (in_tvalid),
        .pkt_in_tlast_i       (in_tlast),
        .pkt_in_tready_o      (in_tready),
        .ipv4_header_tdata_o  (hdr_tdata),
        .ipv4_header_tstrb_o  (hdr_tstrb),
        .ipv4_header_tkeep_o  (hdr_tkeep),
        .ipv4_header_tvalid_o (hdr_tvalid),
        .ipv4_header_tlast_o  (hdr_tlast),
        .ipv4_header_tid_o    (hdr_tid),
        .ipv4_header_tdest_o  (hdr_tdest),
        .ipv4_header_tuser_o  (hdr_tuser),
        .err_short_o          (err_short),
        .err_version_o        (err_version),
        .err_length_o         (err_length),
        .opt_present_o        (opt_present),
        .hdr_count_o          (hdr_count),
        .drop_count_o         (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        bit           emit;
        bit           e_short;
        bit           e_ver;
        bit           e_len;
        bit           opt;
        logic [159:0] hdr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pkt[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         exp_hdr = 0;
    int         exp_drop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!sresetn) begin
                exp_hdr  = 0;
                exp_drop = 0;
            end else if (hdr_tvalid || err_short || err_version || err_length || opt_present) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output cyc=%0d actual tvalid=%b short=%b ver=%b len=%b opt=%b required none",
                             cyc, hdr_tvalid, err_short, err_version, err_length, opt_present);
                end else begin
                    e = sb.pop_front();
                    if (e.emit) exp_hdr++;
                    else exp_drop++;
                    chk("latency_cycle", 160'(cyc), 160'(e.due));
                    chk("tvalid", 160'(hdr_tvalid), 160'(e.emit));
                    chk("tlast", 160'(hdr_tlast), 160'(e.emit));
                    chk("err_short", 160'(err_short), 160'(e.e_short));
                    chk("err_version", 160'(err_version), 160'(e.e_ver));
                    chk("err_length", 160'(err_length), 160'(e.e_len));
                    chk("opt_present", 160'(opt_present), 160'(e.opt));
                    if (e.emit) chk("tdata", hdr_tdata, e.hdr);
                    chk("hdr_count", 160'(hdr_count), 160'(exp_hdr & MASK));
                    chk("drop_count", 160'(drop_count), 160'(exp_drop & MASK));
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_output cyc=%0d actual none required due=%0d emit=%b",
                         cyc, sb[0].due, sb[0].emit);
                void'(sb.pop_front());
            end
        end
    end

    function automatic logic [159:0] rnd_hdr(input logic [3:0] v, input logic [3:0] ihl,
                                              input logic [15:0] len);
        logic [159:0] h;
        h = {$urandom, $urandom, $urandom, $urandom, $urandom};
        h[159:156] = v;
        h[155:152] = ihl;
        h[143:128] = len;
        return h;
    endfunction

    // Packet bytes: header bytes first (possibly truncated), then random payload.
    task automatic mk(input logic [159:0] h, input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) begin
            if (i < 20) pkt.push_back(h[159 - 8*i -: 8]);
            else pkt.push_back(8'($urandom));
        end
    endtask

    task automatic idle(input int n);
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        repeat (n) begin
            in_tdata = {$urandom, $urandom};
            in_tkeep = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        in_tdata  = d;
        in_tkeep  = k;
        in_tlast  = l;
        in_tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Predicts the outcome from the byte count and header bytes, then streams the packet.
    task automatic send_pkt(input int gap_pct);
        int          n;
        int          nb;
        int          dec;
        exp_t        e;
        logic [63:0] d;
        logic [7:0]  k;
        n   = pkt.size();
        nb  = (n + 7) / 8;
        dec = (nb < 3) ? nb - 1 : 2;
        e.e_short = (n < 20);
        e.e_ver   = 1'b0;
        e.e_len   = 1'b0;
        e.opt     = 1'b0;
        e.hdr     = '0;
        if (!e.e_short) begin
            e.e_ver = (pkt[0][7:4] != 4'd4);
            e.e_len = ({pkt[2], pkt[3]} < 16'd20);
            e.opt   = (pkt[0][3:0] > 4'd5);
            for (int i = 0; i < 20; i++) e.hdr = {e.hdr[151:0], pkt[i]};
        end
        e.emit = !(e.e_short || e.e_ver || e.e_len);
        for (int b = 0; b < nb; b++) begin
            while ($urandom_range(99) < gap_pct) idle(1);
            for (int j = 0; j < 8; j++) begin
                d[63 - 8*j -: 8] = (b*8 + j < n) ? pkt[b*8 + j] : 8'($urandom);
                k[7 - j]         = (b*8 + j < n);
            end
            if (b == dec) begin
                e.due = cyc + 1;
                sb.push_back(e);
            end
            drive_beat(d, k, b == nb - 1);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tvalid"}, 160'(hdr_tvalid), 160'(0));
        chk({tag, "_tlast"}, 160'(hdr_tlast), 160'(0));
        chk({tag, "_tdata"}, hdr_tdata, 160'(0));
        chk({tag, "_errs"}, 160'({err_short, err_version, err_length, opt_present}), 160'(0));
        chk({tag, "_hdr_count"}, 160'(hdr_count), 160'(0));
        chk({tag, "_drop_count"}, 160'(drop_count), 160'(0));
    endtask

    initial begin
        logic [159:0] spec_h;
        logic [159:0] h;
        logic [3:0]   v;
        logic [3:0]   ihl;
        logic [15:0]  len;
        spec_h = 160'h45000054_1c46_4000_4006_0000_c0a80001_c0a800c7;

        repeat (3) @(posedge clk);
        #1;
        sresetn = 1'b1;
        chk_zero("reset");
        chk("tready", 160'(in_tready), 160'(1));
        chk("tstrb_tkeep", 160'({hdr_tstrb, hdr_tkeep}), 160'(40'hFF_FFFF_FFFF));
        chk("tid_tdest_tuser", 160'({hdr_tid, hdr_tdest, hdr_tuser}), 160'(0));

        mk(spec_h, 40); send_pkt(0); idle(3);
        mk(spec_h, 16); send_pkt(0); idle(2);
        mk(spec_h, 40); send_pkt(20); idle(2);
        mk(rnd_hdr(4'd6, 4'd5, 16'd84), 40); send_pkt(0); idle(1);
        mk(rnd_hdr(4'd4, 4'd5, 16'd16), 40); send_pkt(0); idle(1);
        mk(rnd_hdr(4'd6, 4'd5, 16'd16), 24); send_pkt(0); idle(1);
        mk(rnd_hdr(4'd4, 4'd6, 16'd60), 60); send_pkt(0); idle(1);
        // Boundary lengths around the third beat and a single-beat runt.
        mk(rnd_hdr(4'd4, 4'd5, 16'd20), 18); send_pkt(0); idle(1);
        mk(rnd_hdr(4'd4, 4'd5, 16'd20), 20); send_pkt(0); idle(1);
        mk(rnd_hdr(4'd4, 4'd5, 16'd20), 3); send_pkt(0); idle(1);
        for (int i = 0; i < 3; i++) begin
            mk(rnd_hdr(4'd4, 4'd5, 16'(100 + i)), 24);
            send_pkt(0);
        end
        idle(4);

        // Reset while the second beat is on the bus; the partial header is lost.
        drive_beat(spec_h[159:96], 8'hFF, 1'b0);
        in_tdata  = spec_h[95:32];
        in_tvalid = 1'b1;
        sresetn   = 1'b0;
        @(posedge clk);
        #1;
        idle(1);
        sresetn = 1'b1;
        chk_zero("midreset");
        mk(spec_h, 40); send_pkt(0); idle(3);

        for (int p = 0; p < 40; p++) begin
            v   = ($urandom_range(7) == 0) ? 4'($urandom) : 4'd4;
            ihl = 4'($urandom_range(4, 7));
            len = ($urandom_range(7) == 0) ? 16'($urandom_range(19)) : 16'($urandom_range(20, 1500));
            h   = rnd_hdr(v, ihl, len);
            mk(h, $urandom_range(1, 64));
            send_pkt(30);
            if ($urandom_range(1) == 0) idle($urandom_range(1, 3));
        end
        idle(10);

        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_leftover actual none required due=%0d emit=%b", sb[0].due, sb[0].emit);
            void'(sb.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
